// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Holds the op encoding, the sequencer states and the iteration count.
package muldiv_pkg;

  localparam int MULDIV_ITERS = 32;
  localparam int CNT_W        = $clog2(MULDIV_ITERS + 1);

  // Codes 6 and 7 are reserved and never accepted.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic op_valid(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
           (op == OP_DIVU) || (op == OP_MTHI)  || (op == OP_MTLO);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_mul(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared sequencer: restoring shift-subtract for divide,
// shift-add for multiply, both operating on unsigned magnitudes.
module muldiv_step (
  input  logic        div_mode,
  input  logic [31:0] acc,
  input  logic [31:0] q,
  input  logic [31:0] operand,
  output logic [31:0] acc_next,
  output logic [31:0] q_next
);

  logic [32:0] shifted;
  logic        fits;
  logic [31:0] diff;
  logic [32:0] sum;

  always_comb begin
    // NOTE: every output of a combinational block is given a default first so
    // no path through it can leave a value held, which would infer a latch.
    acc_next = acc;
    q_next   = q;

    // A set bit 32 means the partial remainder already exceeds any 32-bit
    // divisor, so the 32-bit wrap-around difference is still exact.
    shifted = {acc, q[31]};
    fits    = shifted[32] || (shifted[31:0] >= operand);
    diff    = shifted[31:0] - operand;

    sum = {1'b0, acc} + (q[0] ? {1'b0, operand} : 33'd0);

    if (div_mode) begin
      acc_next = fits ? diff : shifted[31:0];
      q_next   = {q[30:0], fits};
    end else begin
      acc_next = sum[32:1];
      q_next   = {sum[0], q[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: sequential 32-step divide and multiply sharing
// one datapath. Defining MULDIV_FAST_MULT_EN makes MULT/MULTU single-cycle.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULDIV_ITERS);

  op_e    op_in;
  state_e state, state_next;

  logic             accept;
  logic             finish_run;
  logic             needs_run;

  logic [CNT_W-1:0] cnt;
  logic [31:0]      acc, q, operand;
  logic [31:0]      acc_next, q_next;
  logic             div_r;
  logic             neg_q, neg_r;
  logic             div_zero;
  logic [31:0]      a_r;

  logic             a_neg, b_neg;
  logic [31:0]      a_mag, b_mag;

  logic [31:0]      quo, rem;
  logic [63:0]      prod;
  logic [31:0]      hi_d, lo_d;

`ifdef MULDIV_FAST_MULT_EN
  localparam logic FAST_MULT = 1'b1;
  logic [63:0] ext_a, ext_b, fast_prod;

  always_comb begin
    ext_a     = op_is_signed(op_in) ? {{32{a[31]}}, a} : {32'd0, a};
    ext_b     = op_is_signed(op_in) ? {{32{b[31]}}, b} : {32'd0, b};
    fast_prod = ext_a * ext_b;
  end
`else
  localparam logic FAST_MULT = 1'b0;
  logic [63:0] fast_prod;

  assign fast_prod = 64'd0;
`endif

  assign op_in      = op_e'(op);
  assign accept     = (state == ST_IDLE) && start && op_valid(op_in);
  assign finish_run = (state == ST_RUN) && (cnt == LAST_CNT);
  assign needs_run  = op_is_div(op_in) || (op_is_mul(op_in) && !FAST_MULT);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples values from before the edge, whatever the statement order.
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept) state_next = needs_run ? ST_RUN : ST_FIN;
      ST_RUN:  if (finish_run) state_next = ST_FIN;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ST_RUN:  busy = 1'b1;
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  // Sign handling happens here so the step logic only sees magnitudes.
  always_comb begin
    a_neg = op_is_signed(op_in) && a[31];
    b_neg = op_is_signed(op_in) && b[31];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  muldiv_step u_step (
    .div_mode (div_r),
    .acc      (acc),
    .q        (q),
    .operand  (operand),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  // NOTE: the iteration datapath carries no reset; every field is loaded on
  // acceptance before it is read, and reset only needs to clear the FSM, HI, LO.
  always_ff @(posedge clk) begin
    if (accept) begin
      cnt      <= '0;
      acc      <= '0;
      div_r    <= op_is_div(op_in);
      q        <= op_is_div(op_in) ? a_mag : b_mag;
      operand  <= op_is_div(op_in) ? b_mag : a_mag;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= op_is_div(op_in) && (b == 32'd0);
      a_r      <= a;
    end else if ((state == ST_RUN) && (cnt != LAST_CNT)) begin
      cnt <= cnt + 1'b1;
      acc <= acc_next;
      q   <= q_next;
    end
  end

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  always_comb begin
    quo  = neg_q ? -q : q;
    rem  = neg_r ? -acc : acc;
    prod = neg_q ? -{acc, q} : {acc, q};
  end

  always_comb begin
    hi_d = hi;
    lo_d = lo;
    if (accept) begin
      unique case (op_in)
        OP_MTHI:          hi_d = a;
        OP_MTLO:          lo_d = a;
        OP_MULT, OP_MULTU: if (FAST_MULT) {hi_d, lo_d} = fast_prod;
        default: ;
      endcase
    end else if (finish_run) begin
      if (!div_r) begin
        {hi_d, lo_d} = prod;
      end else if (div_zero) begin
        hi_d = a_r;
        lo_d = 32'hFFFF_FFFF;
      end else begin
        hi_d = rem;
        lo_d = quo;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      hi <= hi_d;
      lo <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, latency,
// busy length, done pulse shape, ignored start, reserved ops and reset abort.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_DONE = 0;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_DONE = 33;
  localparam int MUL_BUSY = 33;
`endif

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; start is sampled at the following rising edge
  // (edge 0). done_n counts cycles after edge 0, so "cycle after edge 33" is 33.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int done_n, output int busy_n, output logic done_after);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    done_n = -1;
    busy_n = 0;
    for (int n = 0; n < 60 && done_n < 0; n++) begin
      if (busy) busy_n++;
      if (done) done_n = n;
      else @(negedge clk);
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic check_op(input string tag, input logic [2:0] o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_done, input int exp_busy);
    int   dn, bn;
    logic da;
    run_op(o, av, bv, dn, bn, da);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_done_cycle"}, dn, exp_done);
    check({tag, "_busy_cycles"}, bn, exp_busy);
    check({tag, "_done_single"}, da, 1'b0);
  endtask

  int          dones;
  int          busy_seen;
  logic [31:0] cap_hi, cap_lo;

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;

    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    // Start is presented in the same cycle reset releases: first edge accepts.
    @(negedge clk);
    reset = 1'b1;
    check_op("mtlo_first", OP_MTLO, 32'h0000_0055, 32'h0, 32'h0, 32'h0000_0055, 0, 0);
    check_op("mthi", OP_MTHI, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'h0000_0055, 0, 0);

    check_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MUL_DONE, MUL_BUSY);
    check_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_DONE, MUL_BUSY);
    check_op("mult_negneg", OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'h0000_000F, MUL_DONE, MUL_BUSY);
    check_op("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MUL_DONE, MUL_BUSY);

    check_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 33);
    check_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 33);
    check_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 33, 33);
    check_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 33);
    check_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 33, 33);

    // Reserved codes: nothing starts, HI/LO keep the last result.
    dones = 0; busy_seen = 0;
    start = 1'b1; op = 3'd6; a = 32'h1111_1111; b = 32'd5;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (done) dones++;
      if (busy) busy_seen++;
      @(negedge clk);
    end
    check("reserved_done", dones, 0);
    check("reserved_busy", busy_seen, 0);
    check("reserved_hi", hi, 32'h0);
    check("reserved_lo", lo, 32'hFFFF_FFFF);

    // A second start during a divide is ignored; operand changes do not leak in.
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    dones = 0; cap_hi = '0; cap_lo = '0;
    for (int n = 0; n < 60; n++) begin
      if (n == 5) begin start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3; end
      if (n == 6) start = 1'b0;
      if (n == 10) a = 32'h0000_1234;
      if (done) begin dones++; cap_hi = hi; cap_lo = lo; end
      @(negedge clk);
    end
    check("busy_start_dones", dones, 1);
    check("busy_start_lo", cap_lo, 32'd14);
    check("busy_start_hi", cap_hi, 32'd2);
    check("busy_start_idle", busy, 1'b0);

    // Reset ten cycles into a divide aborts it and clears HI/LO without a clock.
    start = 1'b1; op = OP_DIV; a = 32'h0000_1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0; busy_seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) dones++;
      if (busy) busy_seen++;
      @(negedge clk);
    end
    check("abort_no_done", dones, 0);
    check("abort_no_busy", busy_seen, 0);
    check("abort_hi_after", hi, 32'h0);
    check("abort_lo_after", lo, 32'h0);

    check_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'h0, 32'd3, 33, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request to begin the operation in op.
REQ-004 The block SHALL have the port op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are reserved.
REQ-005 The block SHALL have the port a, input, 32 bits: rs operand taken from regfile rd1.
REQ-006 The block SHALL have the port b, input, 32 bits: rt operand taken from regfile rd2.
REQ-007 The block SHALL have the port busy, output, 1 bit: an operation is in progress.
REQ-008 The block SHALL have the port done, output, 1 bit: one-cycle pulse marking the cycle in which hi and lo are first valid.
REQ-009 The block SHALL have the ports hi and lo, outputs, 32 bits each: the architectural HI/LO registers, which feed the MFHI/MFLO write-back mux.

Function
REQ-010 The block SHALL contain an FSM with states IDLE, RUN and FIN; start SHALL be sampled only in IDLE and ignored in any other state.
REQ-011 On acceptance of start, a, b and op SHALL be latched; later changes to a or b SHALL NOT affect the result.
REQ-012 MTHI and MTLO SHALL load a into hi or lo at the accepting edge, leave the other register unchanged, and pulse done in the following cycle with busy held low.
REQ-013 DIV and DIVU SHALL use a 32-iteration restoring shift-subtract, one iteration per edge.
REQ-014 DIV/DIVU timing SHALL be: start accepted at edge 0; busy high from edge 0 until edge 33; hi/lo loaded and done high in the cycle following edge 33; state then returns to IDLE.
REQ-015 Divide results SHALL be lo = quotient and hi = remainder.
REQ-016 Signed divide SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-017 Divide by zero SHALL complete with normal latency, giving lo = 0xFFFFFFFF and hi = dividend.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-019 MULT and MULTU SHALL produce the full 64-bit product, with {hi,lo} = product; signed and unsigned sign-extension rules apply to 64 bits.
REQ-020 Reserved op codes SHALL be ignored: no state change and no done.
REQ-021 done SHALL never be high for two consecutive cycles.
REQ-022 hi and lo SHALL be modified only at result load or by MTHI/MTLO.

Reset
REQ-023 While reset is low, the FSM SHALL be in IDLE, with busy = 0, done = 0, hi = 0 and lo = 0, independent of clk.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done and no partial hi/lo update.
REQ-025 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-026 With MULDIV_FAST_MULT_EN defined, MULT/MULTU SHALL be single-cycle: {hi,lo} loaded at the accepting edge, done in the next cycle, and busy never asserted.
REQ-027 Without MULDIV_FAST_MULT_EN, MULT/MULTU SHALL use a 32-iteration shift-add on the divider's shift registers, with timing identical to REQ-014; no 32x32 multiplier SHALL be inferred.

Structure
REQ-028 A package muldiv_pkg SHALL hold the op encoding enum, the FSM state enum and the constant MULDIV_ITERS = 32.
REQ-029 The single iteration step SHALL be a combinational sub-module muldiv_step, taking accumulator, operand and mode and returning the next accumulator/quotient.
REQ-030 Sign correction (operand absolute values and result negation) SHALL be done in muldiv_unit.

Verification
REQ-031 The bench SHALL drive MULTU a=0xFFFFFFFF, b=2 and check hi=0x00000001 and lo=0xFFFFFFFE, and SHALL drive MULT with the same operands and check hi=0xFFFFFFFF and lo=0xFFFFFFFE, under both macro settings.
REQ-032 The bench SHALL drive DIV a=0xFFFFFFF9 (-7), b=2 and check lo=0xFFFFFFFD, hi=0xFFFFFFFF, done in the cycle following edge 33, and busy high for exactly 33 cycles.
REQ-033 The bench SHALL drive DIVU a=100, b=0 and check lo=0xFFFFFFFF, hi=0x00000064, and the same for signed DIV 0x80000000 / 0xFFFFFFFF against REQ-018.
REQ-034 The bench SHALL drive MTHI a=0x00001234 with lo preloaded to 0x55 and check hi=0x00001234, lo=0x55 and a single done pulse.
REQ-035 The bench SHALL start a DIV, assert reset low at cycle 10 and release it, and check busy=0, hi=lo=0 and that no done occurs.
REQ-036 The bench SHALL pulse start with DIVU 9/3 while a divide is busy and change a mid-operation, and check that the original result is unaffected and only one done occurs.
